// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder/subtractor with start/done handshake and active-low 7-segment outputs.
// Define BCD_SERIAL_SUB_EN to build the subtract path (NEG pass and neg flag); otherwise every operation is an add.
module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input  logic                      CLOCK_50,
  input  logic                      RST_N,
  input  logic                      start,
  input  logic                      sub,
  input  logic [4*DIGITS-1:0]       a,
  input  logic [4*DIGITS-1:0]       b,
  output logic                      busy,
  output logic                      done,
  output logic [4*(DIGITS+1)-1:0]   sum,
  output logic                      neg,
  output logic                      err,
  output logic [7*(DIGITS+1)-1:0]   hex
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ADD = 2'd1, NEG = 2'd2, DONE = 2'd3} state_t;

  // Returns {carry, digit} for x + y + cin with decimal correction.
  function automatic logic [4:0] bcd_add_digit(input logic [3:0] x, input logic [3:0] y, input logic cin);
    logic [4:0] t;
    t = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
    if (t > 5'd9) return {1'b1, t[3:0] + 4'd6};
    else          return {1'b0, t[3:0]};
  endfunction

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // Segment order a..g from MSB to LSB, active-low; non-decimal codes blank the digit.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  state_t             state_q, state_d;
  logic [W-1:0]       a_q, a_d, b_q, b_d, r_q, r_d;
  logic               sub_q, sub_d, carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [W+3:0]       sum_q, sum_d;
  logic               neg_q, neg_d, err_q, err_d, done_q, done_d, busy_q, busy_d;
  logic               sub_s, go_neg_s;
  logic [4:0]         add_s;
  logic [W+3:0]       shift_s;

`ifdef BCD_SERIAL_SUB_EN
  assign sub_s = sub;
`else
  assign sub_s = sub & 1'b0;
`endif

  // Next-state and datapath; operands and the result shift one digit per cycle so digit 0 is always at [3:0].
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    r_d      = r_q;
    sub_d    = sub_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    sum_d    = sum_q;
    neg_d    = neg_q;
    err_d    = err_q;
    add_s    = 5'd0;
    shift_s  = '0;
    go_neg_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub_s;
          carry_d = sub_s;
          idx_d   = '0;
          r_d     = '0;
          if (has_bad_digit(a) || has_bad_digit(b)) begin
            state_d = DONE;
            sum_d   = '0;
            neg_d   = 1'b0;
            err_d   = 1'b1;
          end else begin
            state_d = ADD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ADD: begin
        add_s   = bcd_add_digit(a_q[3:0], sub_q ? (4'd9 - b_q[3:0]) : b_q[3:0], carry_q);
        shift_s = {add_s[3:0], r_q};
        r_d     = shift_s[W+3:4];
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        carry_d = add_s[4];
        idx_d   = idx_q + IDX_W'(1);
`ifdef BCD_SERIAL_SUB_EN
        go_neg_s = sub_q & ~add_s[4];
`endif
        if (idx_q == LAST) begin
          idx_d = '0;
          if (go_neg_s) begin
            state_d = NEG;
            carry_d = 1'b1;
          end else begin
            state_d = DONE;
            sum_d   = {3'b000, add_s[4] & ~sub_q, r_d};
            neg_d   = 1'b0;
            err_d   = 1'b0;
          end
        end else begin
          state_d = ADD;
        end
      end
`ifdef BCD_SERIAL_SUB_EN
      NEG: begin
        add_s   = bcd_add_digit(4'd9 - r_q[3:0], 4'd0, carry_q);
        shift_s = {add_s[3:0], r_q};
        r_d     = shift_s[W+3:4];
        carry_d = add_s[4];
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST) begin
          idx_d   = '0;
          state_d = DONE;
          sum_d   = {4'b0000, r_d};
          neg_d   = 1'b1;
          err_d   = 1'b0;
        end else begin
          state_d = NEG;
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    done_d = (state_d == DONE);
    busy_d = (state_d == ADD) || (state_d == NEG);
  end

  // State, working registers and registered outputs.
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      neg_q   <= neg_d;
      err_q   <= err_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Display decode of the held result.
  always_comb begin
    hex = '1;
    for (int d = 0; d < DIGITS + 1; d++) begin
      hex[7*d +: 7] = seg7(sum_q[4*d +: 4]);
    end
  end

  assign sum  = sum_q;
  assign neg  = neg_q;
  assign err  = err_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed vector bench for bcd_serial_adder (DIGITS = 4); expectations follow BCD_SERIAL_SUB_EN.
module tb_bcd_serial_adder;

  localparam int DIGITS = 4;

  logic        CLOCK_50 = 1'b0;
  logic        RST_N    = 1'b0;
  logic        start    = 1'b0;
  logic        sub      = 1'b0;
  logic [15:0] a        = 16'h0000;
  logic [15:0] b        = 16'h0000;
  logic        busy, done, neg, err;
  logic [19:0] sum;
  logic [34:0] hex;

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .CLOCK_50(CLOCK_50), .RST_N(RST_N), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .neg(neg), .err(err), .hex(hex)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic [19:0] sum;
    logic        neg;
    logic        err;
    int          lat;
    int          busyc;
  } vec_t;

  vec_t vecs[7];

  localparam logic [34:0] HEX_ZERO  = {5{7'b0000001}};
  localparam logic [34:0] HEX_01234 = {7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_done"}, {63'd0, done}, 64'd0);
    check({tag, "_sum"},  {44'd0, sum},  64'd0);
    check({tag, "_neg"},  {63'd0, neg},  64'd0);
    check({tag, "_err"},  {63'd0, err},  64'd0);
    check({tag, "_hex"},  {29'd0, hex},  {29'd0, HEX_ZERO});
  endtask

  // Issue one operation, scramble the operands after the sampling edge, and time done/busy.
  task automatic run_op(input logic s, input logic [15:0] va, input logic [15:0] vb,
                        output int lat, output int busyc);
    @(negedge CLOCK_50);
    start = 1'b1; sub = s; a = va; b = vb;
    @(posedge CLOCK_50);
    #1;
    start = 1'b0; a = 16'hAAAA; b = 16'h5555;
    lat = -1;
    busyc = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLOCK_50);
      if (busy) busyc++;
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  initial begin
    int lat, busyc, done_cnt, done_at;
    logic [19:0] got_sum;

    vecs[0] = '{"add_carry_out", 1'b0, 16'h9999, 16'h0001, 20'h10000, 1'b0, 1'b0, 4, 4};
`ifdef BCD_SERIAL_SUB_EN
    vecs[1] = '{"sub_nonneg",    1'b1, 16'h0100, 16'h0001, 20'h00099, 1'b0, 1'b0, 4, 4};
    vecs[2] = '{"sub_equal",     1'b1, 16'h1234, 16'h1234, 20'h00000, 1'b0, 1'b0, 4, 4};
    vecs[3] = '{"sub_negative",  1'b1, 16'h0001, 16'h0100, 20'h00099, 1'b1, 1'b0, 8, 8};
`else
    vecs[1] = '{"sub_nonneg",    1'b1, 16'h0100, 16'h0001, 20'h00101, 1'b0, 1'b0, 4, 4};
    vecs[2] = '{"sub_equal",     1'b1, 16'h1234, 16'h1234, 20'h02468, 1'b0, 1'b0, 4, 4};
    vecs[3] = '{"sub_negative",  1'b1, 16'h0001, 16'h0100, 20'h00101, 1'b0, 1'b0, 4, 4};
`endif
    vecs[4] = '{"bad_digit",     1'b0, 16'h00A0, 16'h0000, 20'h00000, 1'b0, 1'b1, 0, 0};
    vecs[5] = '{"add_mid",       1'b0, 16'h0456, 16'h0789, 20'h01245, 1'b0, 1'b0, 4, 4};
    vecs[6] = '{"add_display",   1'b0, 16'h1234, 16'h0000, 20'h01234, 1'b0, 1'b0, 4, 4};

    RST_N = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    check_reset_outputs("reset");
    RST_N = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].sub, vecs[i].a, vecs[i].b, lat, busyc);
      check({vecs[i].name, "_latency"}, 64'(lat),   64'(vecs[i].lat));
      check({vecs[i].name, "_busy"},    64'(busyc), 64'(vecs[i].busyc));
      check({vecs[i].name, "_sum"},     {44'd0, sum}, {44'd0, vecs[i].sum});
      check({vecs[i].name, "_neg"},     {63'd0, neg}, {63'd0, vecs[i].neg});
      check({vecs[i].name, "_err"},     {63'd0, err}, {63'd0, vecs[i].err});
      @(negedge CLOCK_50);
      check({vecs[i].name, "_done_pulse"}, {63'd0, done}, 64'd0);
    end

    check("hex_01234", {29'd0, hex}, {29'd0, HEX_01234});
    check("hex_field_one", {57'd0, hex[27:21]}, {57'd0, 7'b1001111});

    // Restart attempt while busy and again in the DONE cycle must both be ignored.
    @(negedge CLOCK_50);
    start = 1'b1; sub = 1'b0; a = 16'h0012; b = 16'h0034;
    @(posedge CLOCK_50);
    #1;
    start = 1'b0;
    done_cnt = 0;
    done_at = -1;
    got_sum = 20'h0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLOCK_50);
      if (c == 5) check("start_in_done_ignored", {63'd0, busy}, 64'd0);
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = c;
          got_sum = sum;
        end
      end
      start = (c == 1) || (c == 4);
      if (c == 1) begin
        a = 16'h9999;
        b = 16'h9999;
      end
    end
    start = 1'b0;
    check("handshake_done_count", 64'(done_cnt), 64'd1);
    check("handshake_latency",    64'(done_at),  64'd4);
    check("handshake_sum",        {44'd0, got_sum}, {44'd0, 20'h00046});

    // Reset two cycles into an add aborts it.
    @(negedge CLOCK_50);
    start = 1'b1; sub = 1'b0; a = 16'h0011; b = 16'h0022;
    @(posedge CLOCK_50);
    #1;
    start = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    RST_N = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(negedge CLOCK_50);
    RST_N = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLOCK_50);
      if (done) done_cnt++;
    end
    check("abort_no_done", 64'(done_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
